// File: rtl/day10_pkg.sv
// Shared types and helpers for the day-10 machine scheduler: slot/global state encodings,
// the default descriptor layout and the no-solution marker.
package day10_pkg;

    localparam int DEF_NUM_LIGHTS  = 10;
    localparam int DEF_NUM_BUTTONS = 13;
    localparam int DEF_PRESSES_W   = 4;
    localparam int DEF_LW          = $clog2(DEF_NUM_LIGHTS + 1);
    localparam int DEF_BW          = $clog2(DEF_NUM_BUTTONS + 1);

    localparam logic [DEF_PRESSES_W-1:0] NO_SOLUTION = '1;

    typedef enum logic [1:0] {
        SLOT_IDLE   = 2'd0,
        SLOT_LOAD   = 2'd1,
        SLOT_RUN    = 2'd2,
        SLOT_RETIRE = 2'd3
    } slot_state_t;

    typedef enum logic [1:0] {
        GLOB_ACCEPT = 2'd0,
        GLOB_DRAIN  = 2'd1,
        GLOB_DONE   = 2'd2
    } glob_state_t;

    typedef struct packed {
        logic [DEF_LW-1:0]                          num_lights;
        logic [DEF_BW-1:0]                          num_btns;
        logic [DEF_NUM_LIGHTS-1:0]                  target;
        logic [DEF_NUM_BUTTONS*DEF_NUM_LIGHTS-1:0]  buttons;
    } day10_desc_t;

    function automatic int wrap_add(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/day10_machine_scheduler_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping, as onehot grant plus index.
module rr_pick
    import day10_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[wrap_add(int'(ptr), k, N)]) begin
                any = 1'b1;
                grant[wrap_add(int'(ptr), k, N)] = 1'b1;
                idx = IW'(wrap_add(int'(ptr), k, N));
            end
        end
    end

endmodule

// File: rtl/day10_machine_scheduler.sv
// Dispatches machine descriptors over a bank of configure_machine workers, sequences their
// start/ready/accepted handshake and accumulates the saturating puzzle total.
//
// state        | meaning
// SLOT_IDLE    | slot free, may take the next descriptor
// SLOT_LOAD    | descriptor registered, wk_start pulsed
// SLOT_RUN     | worker busy; retire candidate once wk_ready
// SLOT_RETIRE  | result taken, worker ready still high, ignored
// GLOB_ACCEPT  | taking descriptors until one marked last
// GLOB_DRAIN   | last taken, waiting for every slot to go idle
// GLOB_DONE    | total final and held until clear
module day10_machine_scheduler
    import day10_pkg::*;
#(
    parameter int NUM_WORKERS       = 4,
    parameter int MAX_NUM_LIGHTS    = 10,
    parameter int MAX_NUM_BUTTONS   = 13,
    parameter int MAX_NUM_PRESSES_W = 4,
    parameter int SUM_W             = 16,
    localparam int LW  = $clog2(MAX_NUM_LIGHTS + 1),
    localparam int BW  = $clog2(MAX_NUM_BUTTONS + 1),
    localparam int BMW = MAX_NUM_BUTTONS * MAX_NUM_LIGHTS
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clear,
    input  logic                                   job_valid,
    output logic                                   job_ready,
    input  logic                                   job_last,
    input  logic [LW-1:0]                          job_num_lights,
    input  logic [BW-1:0]                          job_num_btns,
    input  logic [MAX_NUM_LIGHTS-1:0]              job_target,
    input  logic [BMW-1:0]                         job_buttons,
    output logic [NUM_WORKERS-1:0]                 wk_start,
    input  logic [NUM_WORKERS-1:0]                 wk_ready,
    output logic [NUM_WORKERS-1:0]                 wk_accepted,
    input  logic [NUM_WORKERS*MAX_NUM_PRESSES_W-1:0] wk_min_presses,
    output logic [NUM_WORKERS*LW-1:0]              wk_num_lights,
    output logic [NUM_WORKERS*BW-1:0]              wk_num_btns,
    output logic [NUM_WORKERS*MAX_NUM_LIGHTS-1:0]  wk_target,
    output logic [NUM_WORKERS*BMW-1:0]             wk_buttons,
    output logic [SUM_W-1:0]                       total_presses,
    output logic                                   total_valid,
    output logic                                   no_solution,
    output logic                                   overflow,
    output logic                                   busy
);

    localparam int IW = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
    localparam int PW = MAX_NUM_PRESSES_W;
    localparam int AW = ((SUM_W > PW) ? SUM_W : PW) + 1;
    localparam logic [SUM_W-1:0] SUM_MAX = '1;

    glob_state_t            glob_state;
    logic [NUM_WORKERS-1:0] idle_vec;
    logic [NUM_WORKERS-1:0] run_vec;
    logic [NUM_WORKERS-1:0] retire_req;
    logic [NUM_WORKERS-1:0] disp_grant;
    logic [NUM_WORKERS-1:0] ret_grant;
    logic [IW-1:0]          disp_ptr;
    logic [IW-1:0]          ret_ptr;
    logic [IW-1:0]          disp_idx;
    logic [IW-1:0]          ret_idx;
    logic                   disp_any;
    logic                   ret_any;
    logic                   handshake;
    logic [PW-1:0]          ret_presses;
    logic [AW-1:0]          sum_wide;

    assign retire_req = run_vec & wk_ready;

    rr_pick #(.N(NUM_WORKERS)) u_disp_pick (
        .req   (idle_vec),
        .ptr   (disp_ptr),
        .grant (disp_grant),
        .idx   (disp_idx),
        .any   (disp_any)
    );

    rr_pick #(.N(NUM_WORKERS)) u_ret_pick (
        .req   (retire_req),
        .ptr   (ret_ptr),
        .grant (ret_grant),
        .idx   (ret_idx),
        .any   (ret_any)
    );

    // job_ready depends on state only, never on job_valid
    assign job_ready   = (glob_state == GLOB_ACCEPT) && disp_any;
    assign handshake   = job_valid && job_ready;
    assign wk_accepted = ret_grant;
    assign busy        = !(&idle_vec);
    assign ret_presses = wk_min_presses[int'(ret_idx)*PW +: PW];
    assign sum_wide    = AW'(total_presses) + AW'(ret_presses);

    for (genvar i = 0; i < NUM_WORKERS; i++) begin : g_slot
        slot_state_t               state;
        logic                      start_r;
        logic [LW-1:0]             lights_r;
        logic [BW-1:0]             btns_r;
        logic [MAX_NUM_LIGHTS-1:0] target_r;
        logic [BMW-1:0]            buttons_r;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state     <= SLOT_IDLE;
                start_r   <= 1'b0;
                lights_r  <= '0;
                btns_r    <= '0;
                target_r  <= '0;
                buttons_r <= '0;
            end else begin
                start_r <= 1'b0;
                case (state)
                    SLOT_IDLE: begin
                        if (handshake && disp_grant[i]) begin
                            lights_r  <= job_num_lights;
                            btns_r    <= job_num_btns;
                            target_r  <= job_target;
                            buttons_r <= job_buttons;
                            start_r   <= 1'b1;
                            state     <= SLOT_LOAD;
                        end
                    end
                    SLOT_LOAD:   state <= SLOT_RUN;
                    SLOT_RUN:    if (ret_grant[i]) state <= SLOT_RETIRE;
                    SLOT_RETIRE: state <= SLOT_IDLE;
                    default:     state <= SLOT_IDLE;
                endcase
            end
        end

        assign idle_vec[i] = (state == SLOT_IDLE);
        assign run_vec[i]  = (state == SLOT_RUN);
        assign wk_start[i] = start_r;
        assign wk_num_lights[i*LW +: LW]                       = lights_r;
        assign wk_num_btns[i*BW +: BW]                         = btns_r;
        assign wk_target[i*MAX_NUM_LIGHTS +: MAX_NUM_LIGHTS]   = target_r;
        assign wk_buttons[i*BMW +: BMW]                        = buttons_r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glob_state    <= GLOB_ACCEPT;
            disp_ptr      <= '0;
            ret_ptr       <= '0;
            total_presses <= '0;
            total_valid   <= 1'b0;
            no_solution   <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (handshake)
                disp_ptr <= IW'(wrap_add(int'(disp_idx), 1, NUM_WORKERS));

            if (ret_any) begin
                ret_ptr <= IW'(wrap_add(int'(ret_idx), 1, NUM_WORKERS));
                if (&ret_presses) begin
                    no_solution <= 1'b1;
                end else if (sum_wide > AW'(SUM_MAX)) begin
                    total_presses <= SUM_MAX;
                    overflow      <= 1'b1;
                end else begin
                    total_presses <= sum_wide[SUM_W-1:0];
                end
            end

            // clear is honoured only when nothing is in flight
            case (glob_state)
                GLOB_ACCEPT: begin
                    if (handshake && job_last) begin
                        glob_state <= GLOB_DRAIN;
                    end else if (clear && !busy) begin
                        total_presses <= '0;
                        no_solution   <= 1'b0;
                        overflow      <= 1'b0;
                    end
                end
                GLOB_DRAIN: begin
                    if (&idle_vec) begin
                        glob_state  <= GLOB_DONE;
                        total_valid <= 1'b1;
                    end
                end
                GLOB_DONE: begin
                    if (clear) begin
                        glob_state    <= GLOB_ACCEPT;
                        total_valid   <= 1'b0;
                        total_presses <= '0;
                        no_solution   <= 1'b0;
                        overflow      <= 1'b0;
                    end
                end
                default: glob_state <= GLOB_ACCEPT;
            endcase
        end
    end

endmodule

// File: tb/tb_day10_machine_scheduler.sv
// Bench for day10_machine_scheduler: behavioural workers with random latency/results and a
// plain-arithmetic model of the saturating puzzle total.
module tb_day10_machine_scheduler;

    localparam int N    = 4;
    localparam int L    = 10;
    localparam int B    = 13;
    localparam int PW   = 4;
    localparam int SW   = 6;
    localparam int LW   = 4;
    localparam int BW   = 4;
    localparam int BML  = B * L;
    localparam int SMAX = (1 << SW) - 1;

    logic              clk;
    logic              rst;
    logic              clear;
    logic              job_valid;
    logic              job_ready;
    logic              job_last;
    logic [LW-1:0]     job_num_lights;
    logic [BW-1:0]     job_num_btns;
    logic [L-1:0]      job_target;
    logic [BML-1:0]    job_buttons;
    logic [N-1:0]      wk_start;
    logic [N-1:0]      wk_ready;
    logic [N-1:0]      wk_accepted;
    logic [N*PW-1:0]   wk_min_presses;
    logic [N*LW-1:0]   wk_num_lights;
    logic [N*BW-1:0]   wk_num_btns;
    logic [N*L-1:0]    wk_target;
    logic [N*BML-1:0]  wk_buttons;
    logic [SW-1:0]     total_presses;
    logic              total_valid;
    logic              no_solution;
    logic              overflow;
    logic              busy;

    day10_machine_scheduler #(
        .NUM_WORKERS(N), .MAX_NUM_LIGHTS(L), .MAX_NUM_BUTTONS(B),
        .MAX_NUM_PRESSES_W(PW), .SUM_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .job_valid(job_valid), .job_ready(job_ready), .job_last(job_last),
        .job_num_lights(job_num_lights), .job_num_btns(job_num_btns),
        .job_target(job_target), .job_buttons(job_buttons),
        .wk_start(wk_start), .wk_ready(wk_ready), .wk_accepted(wk_accepted),
        .wk_min_presses(wk_min_presses),
        .wk_num_lights(wk_num_lights), .wk_num_btns(wk_num_btns),
        .wk_target(wk_target), .wk_buttons(wk_buttons),
        .total_presses(total_presses), .total_valid(total_valid),
        .no_solution(no_solution), .overflow(overflow), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // worker models
    logic [PW-1:0]  wres [N];
    int             wcnt [N];
    bit             wrun [N];
    int             wack [N];
    logic [LW-1:0]  s_lights [N];
    logic [BW-1:0]  s_btns   [N];
    logic [L-1:0]   s_target [N];
    logic [BML-1:0] s_buttons[N];

    int res_q[$];
    int lat_q[$];
    int start_log[$];
    logic [N-1:0] acc_log[$];
    int acc_cyc[$];

    bit             hs_prev;
    bit             hs_last_cycle;
    logic [LW-1:0]  hs_lights;
    logic [BW-1:0]  hs_btns;
    logic [L-1:0]   hs_target;
    logic [BML-1:0] hs_buttons;

    int exp_raw;
    bit exp_nosol;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < N; i++) begin
            wres[i] = '0; wcnt[i] = 0; wrun[i] = 0; wack[i] = 0;
            s_lights[i] = '0; s_btns[i] = '0; s_target[i] = '0; s_buttons[i] = '0;
        end
        wk_ready = '0;
        wk_min_presses = '0;
        res_q.delete(); lat_q.delete(); start_log.delete();
        acc_log.delete(); acc_cyc.delete();
        hs_prev = 0; hs_last_cycle = 0;
        exp_raw = 0; exp_nosol = 0;
    endtask

    // just after the active edge: advance workers, check starts and held descriptors
    task automatic post_edge();
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (wack[i] == 2) begin
                wack[i] = 1;
                wrun[i] = 0;
            end else if (wack[i] == 1) begin
                wack[i] = 0;
                wk_ready[i] = 1'b0;
            end else if (wrun[i] && !wk_ready[i]) begin
                wcnt[i]--;
                if (wcnt[i] <= 0) wk_ready[i] = 1'b1;
            end
        end
        chk("start_after_handshake", 256'($countones(wk_start)), 256'(hs_prev));
        for (int i = 0; i < N; i++) begin
            if (wrun[i]) begin
                chk("held_target", 256'(wk_target[i*L +: L]), 256'(s_target[i]));
                chk("held_buttons", 256'(wk_buttons[i*BML +: BML]), 256'(s_buttons[i]));
            end
            if (wk_start[i]) begin
                chk("start_on_free_worker", 256'(wrun[i] || wack[i] != 0), 256'(0));
                chk("start_lights", 256'(wk_num_lights[i*LW +: LW]), 256'(hs_lights));
                chk("start_btns", 256'(wk_num_btns[i*BW +: BW]), 256'(hs_btns));
                chk("start_target", 256'(wk_target[i*L +: L]), 256'(hs_target));
                chk("start_buttons", 256'(wk_buttons[i*BML +: BML]), 256'(hs_buttons));
                s_lights[i] = hs_lights; s_btns[i] = hs_btns;
                s_target[i] = hs_target; s_buttons[i] = hs_buttons;
                wrun[i] = 1;
                wcnt[i] = (lat_q.size() > 0) ? lat_q.pop_front() : int'($urandom_range(1, 6));
                wres[i] = (res_q.size() > 0) ? PW'(res_q.pop_front()) : PW'($urandom_range(0, 15));
                wk_min_presses[i*PW +: PW] = wres[i];
                if (wres[i] == 4'hF) exp_nosol = 1;
                else exp_raw += int'(wres[i]);
                start_log.push_back(i);
            end
        end
        hs_prev = 0;
    endtask

    // mid-cycle, after inputs settle: record handshake and acknowledges committing at next edge
    task automatic comb_observe();
        #1;
        hs_last_cycle = job_valid && job_ready;
        if (hs_last_cycle) begin
            hs_prev = 1;
            hs_lights = job_num_lights; hs_btns = job_num_btns;
            hs_target = job_target; hs_buttons = job_buttons;
        end
        chk("accept_onehot", 256'($onehot0(wk_accepted)), 256'(1));
        if (wk_accepted != '0) begin
            acc_log.push_back(wk_accepted);
            acc_cyc.push_back(cyc);
        end
        for (int i = 0; i < N; i++) begin
            if (wk_accepted[i]) begin
                chk("accept_only_running_ready", 256'(wk_ready[i] && wrun[i] && wack[i] == 0), 256'(1));
                wack[i] = 2;
            end
        end
    endtask

    task automatic step();
        comb_observe();
        @(posedge clk);
        #1;
        post_edge();
    endtask

    task automatic send_job(input bit last, input int gap, output int waited);
        job_valid = 1'b0;
        repeat (gap) step();
        job_valid      = 1'b1;
        job_last       = last;
        job_num_lights = LW'($urandom_range(1, L));
        job_num_btns   = BW'($urandom_range(1, B));
        job_target     = L'($urandom());
        job_buttons    = BML'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        waited = 0;
        do begin
            step();
            waited++;
        end while (!hs_last_cycle && waited < 300);
        chk("handshake_in_time", 256'(hs_last_cycle), 256'(1));
        job_valid = 1'b0;
        job_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!total_valid && n < 500) begin
            step();
            n++;
        end
        chk("done_in_time", 256'(total_valid), 256'(1));
    endtask

    task automatic check_puzzle(input string tag);
        int et;
        et = (exp_raw > SMAX) ? SMAX : exp_raw;
        chk({tag, "_total"}, 256'(total_presses), 256'(et));
        chk({tag, "_valid"}, 256'(total_valid), 256'(1));
        chk({tag, "_no_solution"}, 256'(no_solution), 256'(exp_nosol));
        chk({tag, "_overflow"}, 256'(overflow), 256'(exp_raw > SMAX));
        chk({tag, "_busy"}, 256'(busy), 256'(0));
        chk({tag, "_ready_in_done"}, 256'(job_ready), 256'(0));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_total", 256'(total_presses), 256'(0));
        chk("clear_valid", 256'(total_valid), 256'(0));
        chk("clear_flags", 256'({no_solution, overflow}), 256'(0));
        chk("clear_ready", 256'(job_ready), 256'(1));
        exp_raw = 0; exp_nosol = 0;
        start_log.delete(); acc_log.delete(); acc_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int s0;
        rst = 1'b1; clear = 1'b0; job_valid = 1'b0; job_last = 1'b0;
        job_num_lights = '0; job_num_btns = '0; job_target = '0; job_buttons = '0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_total", 256'(total_presses), 256'(0));
        chk("rst_flags", 256'({total_valid, no_solution, overflow, busy}), 256'(0));
        chk("rst_wk_start", 256'(wk_start), 256'(0));
        chk("rst_wk_accepted", 256'(wk_accepted), 256'(0));
        chk("rst_descriptors", 256'(wk_target), 256'(0));
        chk("rst_job_ready", 256'(job_ready), 256'(1));

        // four back-to-back jobs fill slots 0..3, fifth stalls until the first retire
        lat_q = '{12, 12, 12, 12};
        res_q = '{2, 3, 1, 5, 4};
        for (int k = 0; k < 4; k++) begin
            send_job(0, 0, w);
            chk("b2b_no_wait", 256'(w), 256'(1));
        end
        send_job(1, 0, w);
        chk("fifth_stalled", 256'(w > 2), 256'(1));
        chk("fifth_after_retire", 256'(acc_log.size() >= 1), 256'(1));
        wait_done();
        chk("b2b_slots", 256'({start_log[0], start_log[1], start_log[2], start_log[3], start_log[4]}),
            256'({32'd0, 32'd1, 32'd2, 32'd3, 32'd0}));
        check_puzzle("b2b");
        do_clear();

        // slots 1 and 2 ready together with retire pointer 0: slot 1 first, slot 2 next cycle
        do_reset();
        lat_q = '{20, 10, 9};
        res_q = '{7, 0, 15};
        send_job(0, 0, w);
        send_job(0, 0, w);
        send_job(1, 0, w);
        wait_done();
        chk("tie_count", 256'(acc_log.size()), 256'(3));
        chk("tie_first", 256'(acc_log[0]), 256'(4'b0010));
        chk("tie_second", 256'(acc_log[1]), 256'(4'b0100));
        chk("tie_gap", 256'(acc_cyc[1] - acc_cyc[0]), 256'(1));
        chk("tie_third", 256'(acc_log[2]), 256'(4'b0001));
        check_puzzle("tie");
        do_clear();

        // saturation: eight results of 9 exceed a 6-bit sum
        for (int k = 0; k < 8; k++) res_q.push_back(9);
        for (int k = 0; k < 8; k++) send_job(k == 7, int'($urandom_range(0, 2)), w);
        wait_done();
        check_puzzle("sat");
        do_clear();

        // dispatch in the same cycle as the only busy slot retires
        lat_q = '{3};
        res_q = '{3, 5, 2};
        send_job(0, 0, w);
        step();
        s0 = start_log[0];
        w = 0;
        while (!wk_ready[s0] && w < 50) begin
            step();
            w++;
        end
        chk("single_ready_seen", 256'(wk_ready[s0]), 256'(1));
        send_job(0, 0, w);
        chk("dispatch_while_retire", 256'(w), 256'(1));
        chk("retire_same_cycle", 256'(acc_log.size()), 256'(1));
        send_job(1, 0, w);
        wait_done();
        chk("other_slot_used", 256'(start_log[1]), 256'((s0 + 1) % N));
        check_puzzle("overlap");
        do_clear();

        // random puzzle
        for (int k = 0; k < 24; k++) send_job(k == 23, int'($urandom_range(0, 3)), w);
        wait_done();
        check_puzzle("random");
        do_clear();

        // asynchronous reset in the middle of draining
        lat_q = '{2, 15, 15};
        res_q = '{5, 5, 5};
        send_job(0, 0, w);
        send_job(0, 0, w);
        send_job(1, 0, w);
        repeat (4) step();
        chk("pre_reset_total", 256'(total_presses), 256'(5));
        chk("pre_reset_busy", 256'(busy), 256'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("async_total", 256'(total_presses), 256'(0));
        chk("async_flags", 256'({total_valid, no_solution, overflow, busy}), 256'(0));
        chk("async_wk_start", 256'(wk_start), 256'(0));
        chk("async_wk_accepted", 256'(wk_accepted), 256'(0));
        chk("async_descriptors", 256'({wk_num_lights, wk_target}), 256'(0));
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        res_q = '{6};
        send_job(1, 0, w);
        wait_done();
        check_puzzle("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
